// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into single-cycle
// press / release / click / double-click / long-press / auto-repeat pulses.
module button_event_decoder #(
  parameter int unsigned LONG_PRESS_CNT       = 50_000_000,
  parameter int unsigned DOUBLE_CLICK_GAP_CNT = 15_000_000,
  parameter int unsigned REPEAT_CNT           = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int unsigned HW = $clog2(LONG_PRESS_CNT + 1);
  localparam int unsigned GW = $clog2(DOUBLE_CLICK_GAP_CNT + 1);
  localparam int unsigned RW = $clog2(REPEAT_CNT + 1);

  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CNT);
  localparam logic [GW-1:0] GAP_MAX  = GW'(DOUBLE_CLICK_GAP_CNT);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CNT);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRESSED   = 3'd1;
  localparam logic [2:0] S_LONG_HELD = 3'd2;
  localparam logic [2:0] S_WAIT_GAP  = 3'd3;
  localparam logic [2:0] S_SECOND    = 3'd4;

  logic          prev_q, prev_d;
  logic [2:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic [GW-1:0] gap_q, gap_d, gap_inc;
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          click_q, click_d;
  logic          dbl_q, dbl_d;
  logic          long_q, long_d;
  logic          rep_pulse_q, rep_pulse_d;

  // Edge detection plus the press-sequence FSM; every event is decided from
  // the current sample and registered on the same edge.
  always_comb begin
    prev_d      = btn_level;
    state_d     = state_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    rep_d       = rep_q;
    press_d     = btn_level & ~prev_q;
    release_d   = ~btn_level & prev_q;
    click_d     = 1'b0;
    dbl_d       = 1'b0;
    long_d      = 1'b0;
    rep_pulse_d = 1'b0;

    // Saturating increments
    hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    gap_inc  = (gap_q  == GAP_MAX)  ? gap_q  : gap_q  + 1'b1;
    rep_inc  = (rep_q  == REP_MAX)  ? rep_q  : rep_q  + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (btn_level && !prev_q) begin
          state_d = S_PRESSED;
          hold_d  = HW'(1);
        end
      end
      S_PRESSED: begin
        if (btn_level) begin
          if (hold_inc == HOLD_MAX) begin
            long_d  = 1'b1;
            state_d = S_LONG_HELD;
            rep_d   = '0;
          end
          hold_d = hold_inc;
        end else begin
          state_d = S_WAIT_GAP;
          gap_d   = GW'(1);
        end
      end
      S_LONG_HELD: begin
        if (btn_level) begin
          if (rep_inc == REP_MAX) begin
            rep_pulse_d = 1'b1;
            rep_d       = '0;
          end else begin
            rep_d = rep_inc;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_GAP: begin
        if (btn_level) begin
          state_d = S_SECOND;
          hold_d  = HW'(1);
        end else if (gap_inc == GAP_MAX) begin
          click_d = 1'b1;
          state_d = S_IDLE;
          gap_d   = gap_inc;
        end else begin
          gap_d = gap_inc;
        end
      end
      S_SECOND: begin
        if (btn_level) begin
          // The first press still counts as a click when the second becomes a long press
          if (hold_inc == HOLD_MAX) begin
            click_d = 1'b1;
            long_d  = 1'b1;
            state_d = S_LONG_HELD;
            rep_d   = '0;
          end
          hold_d = hold_inc;
        end else begin
          dbl_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q      <= 1'b0;
      state_q     <= S_IDLE;
      hold_q      <= '0;
      gap_q       <= '0;
      rep_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      click_q     <= 1'b0;
      dbl_q       <= 1'b0;
      long_q      <= 1'b0;
      rep_pulse_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      rep_q       <= rep_d;
      press_q     <= press_d;
      release_q   <= release_d;
      click_q     <= click_d;
      dbl_q       <= dbl_d;
      long_q      <= long_d;
      rep_pulse_q <= rep_pulse_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign click         = click_q;
  assign double_click  = dbl_q;
  assign long_press    = long_q;
  assign repeat_pulse  = rep_pulse_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG=8, GAP=4, REPEAT=3.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_level = 1'b0;
  logic press_pulse, release_pulse, click, double_click, long_press, repeat_pulse;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // Captured output traces: bit k = value visible during the cycle "at k".
  // Index: 0 press, 1 release, 2 click, 3 double_click, 4 long_press, 5 repeat
  logic [63:0] cap [6];
  string       nm  [6];

  button_event_decoder #(
    .LONG_PRESS_CNT(8),
    .DOUBLE_CLICK_GAP_CNT(4),
    .REPEAT_CNT(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .click(click),
    .double_click(double_click),
    .long_press(long_press),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] b(input int i);
    logic [63:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] every3(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i += 3) m[i] = 1'b1;
    return m;
  endfunction

  // Drive samples 0..47 (inputs set at negedge, sampled at edge k) and record outputs.
  task automatic run_scn(input logic [63:0] pat, input logic [63:0] rst);
    for (int i = 0; i < 6; i++) cap[i] = '0;
    @(negedge clk);
    for (int k = 0; k < 48; k++) begin
      btn_level = pat[k];
      reset     = rst[k];
      @(posedge clk);
      #1;
      cap[0][k+1] = press_pulse;
      cap[1][k+1] = release_pulse;
      cap[2][k+1] = click;
      cap[3][k+1] = double_click;
      cap[4][k+1] = long_press;
      cap[5][k+1] = repeat_pulse;
      @(negedge clk);
    end
    btn_level = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_reset;
    logic [5:0] o;
    @(negedge clk);
    reset = 1'b1;
    btn_level = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    o = {repeat_pulse, long_press, double_click, click, release_pulse, press_pulse};
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (o[i] !== 1'b0) $display("FAIL reset.%s got=%b exp=0", nm[i], o[i]);
      else pass_cnt++;
    end
    btn_level = 1'b0;
  endtask

  task automatic test_short_press;
    logic [63:0] ex [6];
    run_scn(rng(10, 12), rng(0, 1));
    ex[0] = b(11); ex[1] = b(14); ex[2] = b(17);
    ex[3] = '0;    ex[4] = '0;    ex[5] = '0;
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (cap[i] !== ex[i]) $display("FAIL short.%s got=%h exp=%h", nm[i], cap[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_long_hold;
    logic [63:0] ex [6];
    run_scn(rng(10, 24), rng(0, 1));
    ex[0] = b(11); ex[1] = b(26); ex[2] = '0;
    ex[3] = '0;    ex[4] = b(18); ex[5] = b(21) | b(24);
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (cap[i] !== ex[i]) $display("FAIL long.%s got=%h exp=%h", nm[i], cap[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_double_click;
    logic [63:0] ex [6];
    run_scn(rng(10, 11) | rng(14, 15), rng(0, 1));
    ex[0] = b(11) | b(15); ex[1] = b(13) | b(17); ex[2] = '0;
    ex[3] = b(17);         ex[4] = '0;            ex[5] = '0;
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (cap[i] !== ex[i]) $display("FAIL double.%s got=%h exp=%h", nm[i], cap[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_gap_expiry;
    logic [63:0] ex [6];
    run_scn(rng(10, 11) | rng(16, 47), rng(0, 1));
    ex[0] = b(11) | b(17); ex[1] = b(13); ex[2] = b(16);
    ex[3] = '0;            ex[4] = b(24); ex[5] = every3(27, 48);
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (cap[i] !== ex[i]) $display("FAIL gap_expiry.%s got=%h exp=%h", nm[i], cap[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_second_long;
    logic [63:0] ex [6];
    run_scn(rng(10, 11) | rng(14, 47), rng(0, 1));
    ex[0] = b(11) | b(15); ex[1] = b(13); ex[2] = b(22);
    ex[3] = '0;            ex[4] = b(22); ex[5] = every3(25, 48);
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (cap[i] !== ex[i]) $display("FAIL second_long.%s got=%h exp=%h", nm[i], cap[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_hold;
    logic [63:0] ex [6];
    run_scn(rng(10, 47), rng(0, 1) | rng(13, 14));
    ex[0] = b(11) | b(16); ex[1] = '0;    ex[2] = '0;
    ex[3] = '0;            ex[4] = b(23); ex[5] = every3(26, 48);
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (cap[i] !== ex[i]) $display("FAIL reset_mid.%s got=%h exp=%h", nm[i], cap[i], ex[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if ((cap[i] & rng(14, 15)) !== 64'd0)
        $display("FAIL reset_quiet.%s got=%h exp=0", nm[i], cap[i] & rng(14, 15));
      else pass_cnt++;
    end
  endtask

  initial begin
    nm[0] = "press_pulse";  nm[1] = "release_pulse"; nm[2] = "click";
    nm[3] = "double_click"; nm[4] = "long_press";    nm[5] = "repeat_pulse";
    test_reset();
    test_short_press();
    test_long_hold();
    test_double_click();
    test_gap_expiry();
    test_second_long();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
